sample_window_monitor: RTL and testbench
========================================

Name: sample_window_monitor

Overview:
- Downstream consumer of the 12-bit ADC sample stream produced by the ADC read stage.
- Boxcar-averages blocks of 2^AVG_LOG2 samples and compares each average against a programmable inclusive window [lo_thresh, hi_thresh].
- Latches a sticky fault after FAULT_COUNT consecutive out-of-window averages. This fault flag is the circuit-failure indication consumed by the data collector.

Parameters:
- AVG_LOG2, 2, log2 of samples per average (1..6); window size N = 2^AVG_LOG2.
- FAULT_COUNT, 3, consecutive out-of-window averages required to set fault (1..15).

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  asynchronous, active-high reset.
- sample  input  12  unsigned ADC sample.
- sample_valid  input  1  one-cycle pulse; sample is valid this cycle.
- lo_thresh  input  12  window lower bound, inclusive; sampled in COMPARE.
- hi_thresh  input  12  window upper bound, inclusive; sampled in COMPARE.
- fault_clr  input  1  synchronous clear of fault, overrun and consecutive count.
- avg  output  12  most recent block average.
- avg_valid  output  1  one-cycle pulse when avg updates.
- out_of_window  output  1  status of the most recent average; 1 = outside the window.
- fault  output  1  sticky fault flag.
- overrun  output  1  sticky; a sample_valid arrived while the block was not in ACCUM.
- bad_cnt  output  4  current consecutive out-of-window count.

Behaviour:
- Reset (async, rst=1) forces all registers to zero: avg, avg_valid, out_of_window, fault, overrun, bad_cnt, the accumulator, the sample counter; state = ACCUM.
- State ACCUM, on sample_valid:
  - sum <= sum + sample; sum is 12+AVG_LOG2 bits wide, so it cannot overflow.
  - scnt <= scnt + 1.
  - When the accepted sample is the Nth one (scnt == N-1), go to DIVIDE.
- State DIVIDE, 1 cycle:
  - avg <= sum[11+AVG_LOG2:AVG_LOG2] (truncating shift, no rounding).
  - sum <= 0 and scnt <= 0.
  - Go to COMPARE.
- State COMPARE, 1 cycle:
  - out_of_window <= (avg < lo_thresh) || (avg > hi_thresh).
  - avg == lo_thresh and avg == hi_thresh are both in window.
  - If lo_thresh > hi_thresh, every average is out of window.
  - Go to REPORT.
- State REPORT, 1 cycle:
  - avg_valid = 1.
  - If out_of_window: bad_cnt <= bad_cnt + 1, saturating at 15; else bad_cnt <= 0.
  - fault <= 1 when the incremented count reaches FAULT_COUNT.
  - Go to ACCUM.
- Latency: avg_valid asserts exactly 3 cycles after the clock edge that accepts the Nth sample (DIVIDE, COMPARE, REPORT).
- fault stays at 1 while out-of-window averages continue; it clears only via fault_clr or rst.
- fault_clr=1 (any state) clears fault, overrun and bad_cnt.
  - If the same cycle would set fault or increment bad_cnt, the set/increment wins: fault=1, bad_cnt=1.
  - fault_clr does not disturb the accumulator, avg, or the current state.
- sample_valid in DIVIDE, COMPARE or REPORT:
  - The sample is dropped (not added to any block).
  - overrun <= 1, sticky.
  - The normal ADC cadence (about 22 x 28 clk cycles per sample) never triggers this.
- sample_valid held high for several cycles in ACCUM: each high cycle counts as a separate sample.
- Reset mid-block: the partial sum is discarded; the next block starts fresh.

Test Plan:
- Reset, defaults, lo=1000, hi=3000; four samples 2000,2001,2002,2003 -> avg=2001 (8006>>2), avg_valid pulse 3 cycles after the 4th sample, out_of_window=0, bad_cnt=0.
- Three blocks of samples all 4000, hi=3000 -> bad_cnt steps 1,2,3; fault rises with the 3rd avg_valid and stays at 1; a 4th in-window block gives bad_cnt=0, fault still 1; pulse fault_clr -> fault=0.
- Blocks out, out, in, out, out -> bad_cnt 1,2,0,1,2; fault never asserts.
- Boundaries with lo=hi=2048: samples all 2048 -> in window; samples 2047,2048,2048,2048 (sum 8191, avg 2047) -> out of window.
- Block of 4095 x4 -> avg=4095 with no overflow; lo=3000, hi=1000 -> out_of_window=1 for any average.
- Overrun and reset: sample_valid pulsed in the cycle after the 4th sample -> overrun=1 and the next block averages only later samples. Separately, rst asserted after 2 samples -> all outputs 0, and the next 4 samples yield an avg computed from those samples only.

Source files
------------

// File: rtl/sample_window_monitor.sv
// Boxcar-averages blocks of 2^AVG_LOG2 ADC samples and checks each average against an
// inclusive [lo_thresh, hi_thresh] window. A sticky fault is raised after FAULT_COUNT consecutive misses.
module sample_window_monitor #(
    parameter int AVG_LOG2    = 2,
    parameter int FAULT_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sample,
    input  logic        sample_valid,
    input  logic [11:0] lo_thresh,
    input  logic [11:0] hi_thresh,
    input  logic        fault_clr,
    output logic [11:0] avg,
    output logic        avg_valid,
    output logic        out_of_window,
    output logic        fault,
    output logic        overrun,
    output logic [3:0]  bad_cnt
);

    localparam int SW = 12 + AVG_LOG2;
    localparam logic [3:0] FAULT_TH = 4'(FAULT_COUNT);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [AVG_LOG2-1:0]  scnt_q, scnt_d;
    logic [11:0]          avg_q, avg_d;
    logic                 avg_valid_q, avg_valid_d;
    logic                 oow_q, oow_d;
    logic                 fault_q, fault_d;
    logic                 overrun_q, overrun_d;
    logic [3:0]           bad_cnt_q, bad_cnt_d;
    logic [3:0]           bad_inc;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        scnt_d      = scnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        oow_d       = oow_q;
        fault_d     = fault_q;
        overrun_d   = overrun_q;
        bad_cnt_d   = bad_cnt_q;
        bad_inc     = (bad_cnt_q == 4'hF) ? 4'hF : bad_cnt_q + 4'd1;

        // Clear first so that a same-cycle set or increment below takes precedence.
        if (fault_clr) begin
            fault_d   = 1'b0;
            overrun_d = 1'b0;
            bad_cnt_d = 4'd0;
        end

        if (sample_valid && (state_q != ST_ACCUM)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_ACCUM: begin
                if (sample_valid) begin
                    sum_d  = sum_q + {{AVG_LOG2{1'b0}}, sample};
                    scnt_d = scnt_q + AVG_LOG2'(1);
                    if (scnt_q == {AVG_LOG2{1'b1}}) begin
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                avg_d   = sum_q[SW-1:AVG_LOG2];
                sum_d   = '0;
                scnt_d  = '0;
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                oow_d   = (avg_q < lo_thresh) || (avg_q > hi_thresh);
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                avg_valid_d = 1'b1;
                if (oow_q) begin
                    bad_cnt_d = fault_clr ? 4'd1 : bad_inc;
                    if (bad_inc >= FAULT_TH) begin
                        fault_d = 1'b1;
                    end
                end else begin
                    bad_cnt_d = 4'd0;
                end
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            sum_q       <= '0;
            scnt_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            oow_q       <= 1'b0;
            fault_q     <= 1'b0;
            overrun_q   <= 1'b0;
            bad_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            scnt_q      <= scnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            oow_q       <= oow_d;
            fault_q     <= fault_d;
            overrun_q   <= overrun_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign avg           = avg_q;
    assign avg_valid     = avg_valid_q;
    assign out_of_window = oow_q;
    assign fault         = fault_q;
    assign overrun       = overrun_q;
    assign bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_sample_window_monitor.sv
// Scoreboard bench for sample_window_monitor: directed blocks push hand-computed
// {avg, out_of_window, bad_cnt, fault} records; a monitor pops them on each avg_valid.
module tb_sample_window_monitor;

  logic        clk;
  logic        rst;
  logic [11:0] sample;
  logic        sample_valid;
  logic [11:0] lo_thresh;
  logic [11:0] hi_thresh;
  logic        fault_clr;
  logic [11:0] avg;
  logic        avg_valid;
  logic        out_of_window;
  logic        fault;
  logic        overrun;
  logic [3:0]  bad_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [17:0] exp_q[$];
  int          lat_q[$];

  sample_window_monitor #(.AVG_LOG2(2), .FAULT_COUNT(3)) dut (
    .clk(clk),
    .rst(rst),
    .sample(sample),
    .sample_valid(sample_valid),
    .lo_thresh(lo_thresh),
    .hi_thresh(hi_thresh),
    .fault_clr(fault_clr),
    .avg(avg),
    .avg_valid(avg_valid),
    .out_of_window(out_of_window),
    .fault(fault),
    .overrun(overrun),
    .bad_cnt(bad_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [17:0] pack(input logic [11:0] a, input logic o,
                                       input logic [3:0] b, input logic f);
    return {a, o, b, f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && avg_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_avg_valid: act avg=%0d req=no pulse", avg);
      end else begin
        logic [17:0] e;
        int          lc;
        e  = exp_q.pop_front();
        lc = lat_q.pop_front();
        if (pack(avg, out_of_window, bad_cnt, fault) !== e) begin
          n_err++;
          $display("FAIL report: act avg=%0d oow=%0d bad=%0d fault=%0d req avg=%0d oow=%0d bad=%0d fault=%0d",
                   avg, out_of_window, bad_cnt, fault, e[17:6], e[5], e[4:1], e[0]);
        end
        n_cmp++;
        if (cyc != lc) begin
          n_err++;
          $display("FAIL latency: act cycle=%0d req cycle=%0d", cyc, lc);
        end
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic [11:0] v);
    @(negedge clk);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: act pending=%0d req pending=0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic block(input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] s2,
                       input logic [11:0] s3, input logic [11:0] e_avg, input logic e_oow,
                       input logic [3:0] e_bad, input logic e_fault);
    logic [11:0] s[4];
    s = '{s0, s1, s2, s3};
    exp_q.push_back(pack(e_avg, e_oow, e_bad, e_fault));
    for (int i = 0; i < 4; i++) begin
      pulse(s[i]);
      if (i < 3) repeat (2) @(negedge clk);
    end
    lat_q.push_back(cyc + 3);
    drain();
  endtask

  task automatic burst(input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] s2,
                       input logic [11:0] s3, input logic [11:0] e_avg, input logic e_oow,
                       input logic [3:0] e_bad, input logic e_fault);
    logic [11:0] s[4];
    s = '{s0, s1, s2, s3};
    exp_q.push_back(pack(e_avg, e_oow, e_bad, e_fault));
    @(negedge clk);
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample = s[i];
      @(negedge clk);
    end
    sample_valid = 1'b0;
    lat_q.push_back(cyc + 3);
    drain();
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sample       = 12'd0;
    sample_valid = 1'b0;
    lo_thresh    = 12'd1000;
    hi_thresh    = 12'd3000;
    fault_clr    = 1'b0;
    #15;
    check("reset_outputs", {avg, avg_valid, out_of_window, fault, overrun, bad_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic average, truncation, back-to-back samples
    block(12'd2000, 12'd2001, 12'd2002, 12'd2003, 12'd2001, 1'b0, 4'd0, 1'b0);
    lo_thresh = 12'd0; hi_thresh = 12'd4095;
    burst(12'd100, 12'd200, 12'd300, 12'd401, 12'd250, 1'b0, 4'd0, 1'b0);

    // three misses raise fault; an in-window block keeps it set
    lo_thresh = 12'd1000; hi_thresh = 12'd3000;
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd1, 1'b0);
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd2, 1'b0);
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd3, 1'b1);
    block(12'd2000, 12'd2000, 12'd2000, 12'd2000, 12'd2000, 1'b0, 4'd0, 1'b1);
    check("fault_before_clr", fault, 1'b1);
    clr_pulse();
    check("fault_after_clr", fault, 1'b0);

    // out, out, in, out, out: count restarts, no fault
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd1, 1'b0);
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd2, 1'b0);
    block(12'd2000, 12'd2000, 12'd2000, 12'd2000, 12'd2000, 1'b0, 4'd0, 1'b0);
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd1, 1'b0);
    block(12'd4000, 12'd4000, 12'd4000, 12'd4000, 12'd4000, 1'b1, 4'd2, 1'b0);

    // inclusive bounds with lo == hi
    lo_thresh = 12'd2048; hi_thresh = 12'd2048;
    block(12'd2048, 12'd2048, 12'd2048, 12'd2048, 12'd2048, 1'b0, 4'd0, 1'b0);
    block(12'd2047, 12'd2048, 12'd2048, 12'd2048, 12'd2047, 1'b1, 4'd1, 1'b0);

    // full-scale samples, then an inverted window
    lo_thresh = 12'd0; hi_thresh = 12'd4095;
    block(12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b0, 4'd0, 1'b0);
    lo_thresh = 12'd3000; hi_thresh = 12'd1000;
    block(12'd2000, 12'd2000, 12'd2000, 12'd2000, 12'd2000, 1'b1, 4'd1, 1'b0);
    block(12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 1'b1, 4'd2, 1'b0);
    clr_pulse();
    check("bad_cnt_after_clr", bad_cnt, 4'd0);
    check("overrun_idle", overrun, 1'b0);

    // a sample arriving in the cycle after the 4th is dropped and flags overrun
    lo_thresh = 12'd1000; hi_thresh = 12'd3000;
    exp_q.push_back(pack(12'd1000, 1'b0, 4'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      pulse(12'd1000);
      repeat (2) @(negedge clk);
    end
    sample       = 12'd1000;
    sample_valid = 1'b1;
    @(negedge clk);
    lat_q.push_back(cyc + 3);
    sample       = 12'd4000;
    @(negedge clk);
    sample_valid = 1'b0;
    drain();
    check("overrun_set", overrun, 1'b1);
    block(12'd1200, 12'd1200, 12'd1200, 12'd1200, 12'd1200, 1'b0, 4'd0, 1'b0);
    check("overrun_sticky", overrun, 1'b1);
    clr_pulse();
    check("overrun_cleared", overrun, 1'b0);

    // reset mid-block discards the partial sum
    pulse(12'd3000);
    pulse(12'd3000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midblock_reset_outputs", {avg, avg_valid, out_of_window, fault, overrun, bad_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    block(12'd1500, 12'd1501, 12'd1502, 12'd1503, 12'd1501, 1'b0, 4'd0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
